// File: rtl/bit_serial_alu_ctrl.sv
// Bit-serial ALU sequencer: runs one WIDTH-bit operation through a single-bit slice, LSB first.
// Optional abort input enabled by defining BSALU_ABORT_EN.
module bit_serial_alu_ctrl #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       cntrl,
`ifdef BSALU_ABORT_EN
  input  logic             abort,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             negative,
  output logic             zero,
  output logic             overflow,
  output logic             carry_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, res_sh_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] result_q, result_d;
  logic             neg_q, neg_d, zero_q, zero_d, ovf_q, ovf_d, cout_q, cout_d;
  logic             load, shift;

  logic             bb, slice_out, slice_cout, is_arith;
  logic [WIDTH-1:0] res_next;

  // Single-bit ALU slice; sub reuses the adder with B inverted and carry preloaded to 1
  always_comb begin
    bb         = b_sh_q[0] ^ op_q[0];
    slice_out  = 1'b0;
    slice_cout = 1'b0;
    is_arith   = (op_q[2:1] == 2'b01);
    case (op_q)
      3'b000: slice_out = b_sh_q[0];
      3'b010,
      3'b011: begin
        slice_out  = a_sh_q[0] ^ bb ^ carry_q;
        slice_cout = (a_sh_q[0] & bb) | (a_sh_q[0] & carry_q) | (bb & carry_q);
      end
      3'b100: slice_out = a_sh_q[0] & b_sh_q[0];
      3'b101: slice_out = a_sh_q[0] | b_sh_q[0];
      3'b110: slice_out = a_sh_q[0] ^ b_sh_q[0];
      default: slice_out = 1'b0;
    endcase
    res_next = {slice_out, res_sh_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    result_d = result_q;
    neg_d    = neg_q;
    zero_d   = zero_q;
    ovf_d    = ovf_q;
    cout_d   = cout_q;
    load     = 1'b0;
    shift    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          carry_d = cntrl[0];
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        shift   = 1'b1;
        carry_d = slice_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          // carry_q here is the carry into the MSB
          state_d  = S_DONE;
          result_d = res_next;
          neg_d    = res_next[WIDTH-1];
          zero_d   = (res_next == '0);
          cout_d   = is_arith & slice_cout;
          ovf_d    = is_arith & (carry_q ^ slice_cout);
        end
`ifdef BSALU_ABORT_EN
        if (abort) begin
          state_d  = S_IDLE;
          result_d = result_q;
          neg_d    = neg_q;
          zero_d   = zero_q;
          cout_d   = cout_q;
          ovf_d    = ovf_q;
        end
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      neg_q    <= 1'b0;
      zero_q   <= 1'b0;
      ovf_q    <= 1'b0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      neg_q    <= neg_d;
      zero_q   <= zero_d;
      ovf_q    <= ovf_d;
      cout_q   <= cout_d;
    end
  end

  // Operand and partial-result shift registers carry no reset; every bit is rewritten per op
  always_ff @(posedge clk) begin
    if (load) begin
      a_sh_q <= a;
      b_sh_q <= b;
      op_q   <= cntrl;
    end else if (shift) begin
      a_sh_q   <= a_sh_q >> 1;
      b_sh_q   <= b_sh_q >> 1;
      res_sh_q <= res_next;
    end
  end

  assign busy      = (state_q == S_RUN);
  assign done      = (state_q == S_DONE);
  assign result    = result_q;
  assign negative  = neg_q;
  assign zero      = zero_q;
  assign overflow  = ovf_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_bit_serial_alu_ctrl.sv
// Self-checking bench for bit_serial_alu_ctrl: directed cases plus random ops against an arithmetic model.
module tb_bit_serial_alu_ctrl;
  localparam int WIDTH = 64;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic [2:0]       cntrl;
`ifdef BSALU_ABORT_EN
  logic             abort = 1'b0;
`endif
  logic             busy, done, negative, zero, overflow, carry_out;
  logic [WIDTH-1:0] result;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [WIDTH-1:0] r;
    logic n, z, v, c;
  } exp_t;

  bit_serial_alu_ctrl #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b), .cntrl(cntrl),
`ifdef BSALU_ABORT_EN
    .abort(abort),
`endif
    .busy(busy), .done(done), .result(result), .negative(negative),
    .zero(zero), .overflow(overflow), .carry_out(carry_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic exp_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic [2:0] op);
    exp_t e;
    logic [WIDTH:0] wide;
    e = '0;
    case (op)
      3'b000: e.r = y;
      3'b010: begin
        wide = {1'b0, x} + {1'b0, y};
        e.r = wide[WIDTH-1:0];
        e.c = wide[WIDTH];
        e.v = (x[WIDTH-1] == y[WIDTH-1]) && (e.r[WIDTH-1] != x[WIDTH-1]);
      end
      3'b011: begin
        wide = {1'b0, x} + {1'b0, ~y} + 1;
        e.r = wide[WIDTH-1:0];
        e.c = wide[WIDTH];
        e.v = (x[WIDTH-1] != y[WIDTH-1]) && (e.r[WIDTH-1] != x[WIDTH-1]);
      end
      3'b100: e.r = x & y;
      3'b101: e.r = x | y;
      3'b110: e.r = x ^ y;
      default: e.r = '0;
    endcase
    e.n = e.r[WIDTH-1];
    e.z = (e.r == '0);
    return e;
  endfunction

  // One operation; inj >= 0 drives a spurious start for one edge that many edges into the run
  task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_in,
                        input logic [2:0] op, input int inj);
    exp_t e;
    int   n;
    bit   seen;
    e = model(ta, tb_in, op);
    @(negedge clk);
    a = ta; b = tb_in; cntrl = op; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    cntrl = 3'($urandom);
    chk("busy_after_start", WIDTH'(busy), WIDTH'(1));
    n = 0; seen = 0;
    while (n < WIDTH + 8 && !seen) begin
      if (n == inj) begin
        start = 1'b1; cntrl = 3'b100;
      end
      @(posedge clk); #1;
      n++;
      start = 1'b0;
      if (done) seen = 1;
    end
    chk("done_seen", WIDTH'(seen), WIDTH'(1));
    chk("latency", WIDTH'(n), WIDTH'(WIDTH));
    chk("busy_in_done", WIDTH'(busy), WIDTH'(0));
    chk("result", result, e.r);
    chk("negative", WIDTH'(negative), WIDTH'(e.n));
    chk("zero", WIDTH'(zero), WIDTH'(e.z));
    chk("overflow", WIDTH'(overflow), WIDTH'(e.v));
    chk("carry_out", WIDTH'(carry_out), WIDTH'(e.c));
    @(posedge clk); #1;
    chk("done_single", WIDTH'(done), WIDTH'(0));
    chk("idle_after_done", WIDTH'(busy), WIDTH'(0));
  endtask

  initial begin
    int dcount;
    logic [2:0] rop;
    reset_n = 1'b0; start = 1'b0; a = '0; b = '0; cntrl = '0;
    #3;
    chk("rst_result", result, '0);
    chk("rst_flags", WIDTH'({busy, done, negative, zero, overflow, carry_out}), '0);
    repeat (2) @(posedge clk);
    @(negedge clk); reset_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (busy || done) dcount++;
    end
    chk("idle_quiet", WIDTH'(dcount), '0);

    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, -1);
    chk("add_wrap_literal", WIDTH'({zero, carry_out, overflow, negative}), WIDTH'(4'b1100));
    run_op(64'd5, 64'd7, 3'b011, -1);
    chk("sub_neg_literal", result, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 3'b010, -1);
    chk("ovf_literal", result, 64'h8000_0000_0000_0000);
    run_op(64'hF0F0, 64'hFF00, 3'b110, 10);
    chk("xor_literal", result, 64'h0FF0);
    run_op(64'h1234, 64'h5678, 3'b001, -1);
    run_op(64'h1234, 64'h5678, 3'b111, -1);

    for (int k = 0; k < 16; k++) begin
      rop = 3'($urandom);
      run_op({$urandom, $urandom}, {$urandom, $urandom}, rop, -1);
    end

    run_op(64'd1, 64'd1, 3'b010, -1);
    @(negedge clk);
    a = 64'd3; b = 64'd4; cntrl = 3'b010; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (29) @(posedge clk);
    @(negedge clk); #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_result", result, '0);
    chk("midrst_flags", WIDTH'({busy, done, negative, zero, overflow, carry_out}), '0);
    @(negedge clk); reset_n = 1'b1;
    dcount = 0;
    for (int i = 0; i < 70; i++) begin
      @(posedge clk); #1;
      if (done || busy) dcount++;
    end
    chk("midrst_no_done", WIDTH'(dcount), '0);
    chk("midrst_result_held", result, '0);
    run_op(64'd3, 64'd4, 3'b010, -1);
    chk("after_rst_add", result, 64'd7);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/bit_serial_alu_ctrl.md
Name: bit_serial_alu_ctrl

Overview:
Sequencer that runs a full-width ALU operation through one single-bit ALU slice, one bit per cycle, LSB first.
- Latches the operands and control code.
- Owns the carry flip-flop between slices and shifts the result in.
- Computes negative/zero/overflow/carry flags on completion.
- Serves as the area-minimal ALU option for the multicycle/pipelined CPU datapath.

Parameters:
WIDTH, 64, operand/result width in bits (>=2)

Ports:
clk  input  1  system clock, all state updates on rising edge
reset_n  input  1  asynchronous, active-low reset
start  input  1  request a new operation; sampled only in IDLE
a  input  WIDTH  operand A; captured on the accepted start cycle
b  input  WIDTH  operand B; captured on the accepted start cycle
cntrl  input  3  op code: 000 pass B, 010 add, 011 sub, 100 and, 101 or, 110 xor; captured with operands
busy  output  1  high while an operation is in progress (RUN state)
done  output  1  single-cycle pulse when result and flags become valid
result  output  WIDTH  result of the last completed operation
negative  output  1  result[WIDTH-1] of the last completed operation
zero  output  1  result == 0 for the last completed operation
overflow  output  1  signed overflow (add/sub only, else 0)
carry_out  output  1  carry out of MSB (add/sub only, else 0)

Behaviour:
- Reset (async, reset_n=0): state=IDLE; busy=0, done=0, result=0, negative=0, zero=0, overflow=0, carry_out=0; bit counter=0, carry FF=0.
- States: IDLE, RUN, DONE.
- IDLE:
  - If start=1: latch a, b, cntrl into shift registers.
  - Preload carry FF with cntrl[0] (1 for sub, giving two's complement with inverted B). Go to RUN with counter=0.
- RUN, one bit per cycle:
  - Slice inputs: a_sh[0], b_sh[0], carry FF, latched cntrl.
  - Slice output shifts into result shift register at MSB side. Carry FF <= slice carryout. Operand registers shift right.
  - Counter increments. When counter==WIDTH-1, record carry into MSB (current carry FF value) and go to DONE after that bit.
- DONE (exactly one cycle):
  - done=1, busy=0.
  - result, negative, zero, carry_out, overflow update to the new values on the transition into DONE.
  - overflow = carry into MSB XOR carry out of MSB.
  - Return to IDLE next cycle.
- Latency: start accepted at edge N; busy high for edges N+1..N+WIDTH; done high in the cycle after edge N+WIDTH (WIDTH+1 cycles start-to-done).
- Outputs hold their values from the last completed operation until the next DONE. Result registers are not visible mid-operation: use a separate shadow register, loaded only on the transition into DONE.
- start while busy or in DONE: ignored, no queuing.
- Invalid cntrl (001, 111): run the full WIDTH cycles; result=0, zero=1, negative=0, carry_out=0, overflow=0.
- Flags for logic ops and pass B: carry_out=0, overflow=0; negative and zero computed from result.
- reset_n asserted mid-RUN: operation discarded, all outputs return to reset values, no done pulse.

Optional Feature:
Macro BSALU_ABORT_EN.
- Defined: adds input port abort (1 bit). abort=1 in RUN returns to IDLE on the next edge; no done pulse; result and flags keep the previous completed values; abort in IDLE/DONE has no effect.
- Undefined: no abort port; every accepted operation runs to completion.

Test Plan:
- Reset then idle: reset_n=0 mid-cycle, no clock -> all outputs 0 immediately; after release with start=0 for 10 cycles -> busy=0, done=0.
- Add wrap: a=0xFFFF_FFFF_FFFF_FFFF, b=1, cntrl=010 -> done exactly 65 cycles after start; result=0, zero=1, carry_out=1, overflow=0, negative=0.
- Sub negative: a=5, b=7, cntrl=011 -> result=0xFFFF_FFFF_FFFF_FFFE, negative=1, carry_out=0, overflow=0.
- Signed overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=1, cntrl=010 -> result=0x8000_0000_0000_0000, overflow=1, negative=1, carry_out=0.
- Logic ops and start-while-busy: a=0xF0F0, b=0xFF00, cntrl=110 -> result=0x0FF0, carry_out=0, overflow=0. A second start with cntrl=100 at cycle 10 of this op is ignored; only one done pulse.
- Reset mid-op: a=3, b=4, cntrl=010, reset_n low at cycle 30 -> no done, result=0. A new op after release (a=3, b=4) -> result=7 at cycle 65.
